// File: rtl/regfile_seq_pkg.sv
// Shared types and defaults for the register-file burst sequencer.
package regfile_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/regfile_seq_master.sv
// Initiator-side burst sequencer for the 8 x 16-bit register file.
// LOAD streams words into the write port; DUMP reads through port A and
// streams them out. Optional running checksum is enabled by defining
// REGFILE_SEQ_CHECKSUM_EN; without it the checksum output is tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command; only state with cmd_ready high
// LOAD  | accepting in_* beats, each written directly to the reg file
// DUMP  | reading reg file via port A into a one-deep output register
module regfile_seq_master
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              Write_En,
    output logic [ADDR_W-1:0] Write_Addr,
    output logic [DATA_W-1:0] Write_Data,
    output logic [ADDR_W-1:0] Read_Addr_A,
    input  logic [DATA_W-1:0] OutA
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ZERO = '0;

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                done_q, done_d;

    logic load_beat;
    logic dump_capture;
    logic out_hs;
    logic cmd_accept;

    assign cmd_accept   = (state_q == ST_IDLE) && cmd_valid;
    assign load_beat    = (state_q == ST_LOAD) && in_valid;
    assign dump_capture = (state_q == ST_DUMP) && (remaining_q != REM_ZERO)
                          && (!out_valid_q || out_ready);
    assign out_hs       = out_valid_q && out_ready;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign in_ready    = (state_q == ST_LOAD);
    // Write goes out on the same cycle the beat is accepted; reset masks it.
    assign Write_En    = load_beat && !rst;
    assign Write_Addr  = addr_q;
    assign Write_Data  = in_data;
    assign Read_Addr_A = addr_q;

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

    // Next-state and datapath updates for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_base;
                    remaining_d = cmd_count;
                    if (cmd_count == REM_ZERO) begin
                        done_d = 1'b1;
                    end else if (cmd_op == OP_DUMP) begin
                        state_d = ST_DUMP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (in_valid) begin
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_DUMP: begin
                if (dump_capture) begin
                    out_data_d  = OutA;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == REM_ONE);
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - REM_ONE;
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                // Final word leaves: nothing remains so no capture competes.
                if (out_hs && out_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

`ifdef REGFILE_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Sum of every word moved: written beats in LOAD, handshaken words in DUMP.
    always_comb begin
        checksum_d = checksum_q;
        if (cmd_accept) begin
            checksum_d = '0;
        end else if (load_beat) begin
            checksum_d = checksum_q + in_data;
        end else if ((state_q == ST_DUMP) && out_hs) begin
            checksum_d = checksum_q + out_data_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_cmd_accept;
    assign unused_cmd_accept = cmd_accept;
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_seq_master.sv
// Directed bench: regfile_seq_master beside a behavioural 8 x 16 register file.
module tb_regfile_seq_master;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

`ifdef REGFILE_SEQ_CHECKSUM_EN
    localparam logic [15:0] CKS_T1 = 16'h026A;
    localparam logic [15:0] CKS_T6 = 16'h0001;
`else
    localparam logic [15:0] CKS_T1 = 16'h0000;
    localparam logic [15:0] CKS_T6 = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_count;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready, out_last, done;
    logic [DATA_W-1:0] out_data, checksum;
    logic              Write_En;
    logic [ADDR_W-1:0] Write_Addr, Read_Addr_A;
    logic [DATA_W-1:0] Write_Data, OutA;

    always #5 clk = ~clk;

    regfile_seq_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done), .checksum(checksum),
        .Write_En(Write_En), .Write_Addr(Write_Addr), .Write_Data(Write_Data),
        .Read_Addr_A(Read_Addr_A), .OutA(OutA)
    );

    // Register file model: one write port, combinational read port A.
    logic [DATA_W-1:0] mem [8];
    always @(posedge clk) if (Write_En) mem[Write_Addr] <= Write_Data;
    assign OutA = mem[Read_Addr_A];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: logs writes, output handshakes, done pulses, command accepts.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  wr_a[$];
    logic [15:0] wr_d[$];
    int          wr_c[$];
    logic [15:0] dq_d[$];
    logic        dq_l[$];
    int          dq_c[$];
    int          done_n = 0;
    int          ov_n = 0;
    int          acc_cyc = 0;

    always @(negedge clk) begin
        if (Write_En) begin
            wr_a.push_back(Write_Addr);
            wr_d.push_back(Write_Data);
            wr_c.push_back(cyc);
        end
        if (out_valid) ov_n++;
        if (out_valid && out_ready) begin
            dq_d.push_back(out_data);
            dq_l.push_back(out_last);
            dq_c.push_back(cyc);
        end
        if (done) done_n++;
        if (cmd_valid && cmd_ready && !rst) acc_cyc = cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic op, input logic [2:0] base, input logic [3:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        cmd_count = cnt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load_words(input logic [15:0] w [8], input int n, input logic bubble);
        for (int i = 0; i < n; i++) begin
            if (bubble && i > 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = w[i];
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("load_done", done, 1);
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] wa [8];
        logic [15:0] exp_d [8];
        int wb, db, dn, ob;

        rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_base = 0; cmd_count = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", Write_En, 0);
        tick();
        rst = 1'b0;
        tick();

        // Preload regs 6, 7 so later dumps have known contents.
        wa = '{16'h0606, 16'h0707, 0, 0, 0, 0, 0, 0};
        send_cmd(1'b0, 3'd6, 4'd2);
        load_words(wa, 2, 1'b0);
        tick();

        // Test 1: LOAD base 0, count 6, in_valid held high.
        wb = wr_a.size(); dn = done_n;
        wa = '{16'h12, 16'h34, 16'h56, 16'h78, 16'h9A, 16'hBC, 0, 0};
        send_cmd(1'b0, 3'd0, 4'd6);
        chk("t1_cmd_ready_busy", cmd_ready, 0);
        chk("t1_in_ready", in_ready, 1);
        load_words(wa, 6, 1'b0);
        chk("t1_checksum", checksum, CKS_T1);
        chk("t1_nwrites", wr_a.size() - wb, 6);
        for (int i = 0; i < 6; i++) begin
            if (wr_a.size() > wb + i) begin
                chk("t1_waddr", wr_a[wb+i], i);
                chk("t1_wdata", wr_d[wb+i], wa[i]);
                chk("t1_wcyc", wr_c[wb+i] - wr_c[wb], i);
            end
            chk("t1_mem", mem[i], wa[i]);
        end
        tick();
        chk("t1_done_once", done_n - dn, 1);
        chk("t1_done_low", done, 0);

        // Test 3: DUMP base 0, count 8, out_ready high.
        db = dq_d.size(); dn = done_n;
        exp_d = '{16'h12, 16'h34, 16'h56, 16'h78, 16'h9A, 16'hBC, 16'h0606, 16'h0707};
        out_ready = 1'b1;
        send_cmd(1'b1, 3'd0, 4'd8);
        wait_done(20);
        chk("t3_nwords", dq_d.size() - db, 8);
        for (int i = 0; i < 8; i++) begin
            if (dq_d.size() > db + i) begin
                chk("t3_data", dq_d[db+i], exp_d[i]);
                chk("t3_last", dq_l[db+i], (i == 7) ? 1 : 0);
                chk("t3_cyc", dq_c[db+i], acc_cyc + 1 + i);
            end
        end
        tick();
        chk("t3_done_once", done_n - dn, 1);
        chk("t3_out_valid_off", out_valid, 0);
        chk("t3_cmd_ready", cmd_ready, 1);

        // Test 4: DUMP base 2, count 3, stall 3 cycles after first out_valid.
        db = dq_d.size(); dn = done_n;
        out_ready = 1'b0;
        send_cmd(1'b1, 3'd2, 4'd3);
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!out_valid && k < 10) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t4_first_valid", out_valid, 1);
        chk("t4_first_data", out_data, 16'h56);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_data", out_data, 16'h56);
            chk("t4_hold_last", out_last, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(10);
        exp_d = '{16'h56, 16'h78, 16'h9A, 0, 0, 0, 0, 0};
        chk("t4_nwords", dq_d.size() - db, 3);
        for (int i = 0; i < 3; i++) begin
            if (dq_d.size() > db + i) begin
                chk("t4_data", dq_d[db+i], exp_d[i]);
                chk("t4_last", dq_l[db+i], (i == 2) ? 1 : 0);
            end
        end
        tick();
        chk("t4_done_once", done_n - dn, 1);

        // Test 2: LOAD base 6, count 4, bubble between beats (wraps 7 -> 0).
        wb = wr_a.size();
        wa = '{16'hDE, 16'hF0, 16'h11, 16'h22, 0, 0, 0, 0};
        send_cmd(1'b0, 3'd6, 4'd4);
        load_words(wa, 4, 1'b1);
        chk("t2_nwrites", wr_a.size() - wb, 4);
        for (int i = 0; i < 4; i++) begin
            if (wr_a.size() > wb + i) begin
                chk("t2_waddr", wr_a[wb+i], (6 + i) % 8);
                chk("t2_wdata", wr_d[wb+i], wa[i]);
                chk("t2_wgap", wr_c[wb+i] - wr_c[wb], 2 * i);
            end
        end
        chk("t2_mem6", mem[6], 16'hDE);
        chk("t2_mem7", mem[7], 16'hF0);
        chk("t2_mem0", mem[0], 16'h11);
        chk("t2_mem1", mem[1], 16'h22);
        chk("t2_mem2_kept", mem[2], 16'h56);
        tick();

        // Test 5a: count 0 completes immediately with no transfers.
        wb = wr_a.size(); dn = done_n; ob = ov_n;
        in_valid = 1'b1; in_data = 16'h5555;
        send_cmd(1'b0, 3'd3, 4'd0);
        chk("t5_zero_done", done, 1);
        chk("t5_zero_ready", cmd_ready, 1);
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t5_zero_nwrites", wr_a.size() - wb, 0);
        chk("t5_zero_nvalid", ov_n - ob, 0);
        chk("t5_zero_done_once", done_n - dn, 1);
        tick();

        // Test 5b: reset on beat 2 of a 5-beat LOAD.
        wb = wr_a.size(); dn = done_n;
        send_cmd(1'b0, 3'd0, 4'd5);
        in_valid = 1'b1; in_data = 16'h1001;
        tick();
        in_data = 16'h1002; rst = 1'b1;
        #2;
        chk("t5_we_in_rst", Write_En, 0);
        tick();
        rst = 1'b0;
        chk("t5_rst_idle", cmd_ready, 1);
        chk("t5_rst_in_ready", in_ready, 0);
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t5_rst_nwrites", wr_a.size() - wb, 1);
        if (wr_a.size() > wb) begin
            chk("t5_rst_waddr", wr_a[wb], 0);
            chk("t5_rst_wdata", wr_d[wb], 16'h1001);
        end
        chk("t5_rst_no_done", done_n - dn, 0);
        chk("t5_mem0", mem[0], 16'h1001);
        chk("t5_mem1_kept", mem[1], 16'h22);

        // Test 6: checksum wraps modulo 2**16.
        wa = '{16'hFFFF, 16'h0002, 0, 0, 0, 0, 0, 0};
        send_cmd(1'b0, 3'd4, 4'd2);
        load_words(wa, 2, 1'b0);
        chk("t6_checksum", checksum, CKS_T6);
        tick();
        tick();
        chk("t6_checksum_hold", checksum, CKS_T6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
